// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing decoder: recovers hcount/vcount, line and frame
// strobes, measured line/frame totals and a lock indication from sync/blank inputs.
module vga_timing_decoder #(
  parameter int H_TOTAL     = 1344,
  parameter int V_TOTAL     = 806,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        line_start,
  output logic        frame_start,
  output logic [10:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic        locked,
  output logic [7:0]  err_cnt
);

  localparam logic [11:0] HTotalC     = 12'(H_TOTAL);
  localparam logic [11:0] VTotalC     = 12'(V_TOTAL);
  localparam logic [3:0]  LockFramesC = 4'(LOCK_FRAMES);
  localparam logic [10:0] CountMaxC   = 11'h7FF;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  state_e      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [7:0]  errCnt_q, errCnt_d;
  logic        lineErr_q, lineErr_d;
  logic        locked_q;
  logic        hblnk_q, vblnk_line_q;
  logic        hsync_q, vsync_q, hblnkOut_q, vblnkOut_q;
  logic        lineStart_q, frameStart_q;
  logic [10:0] hcount_q, vcount_q, hTotal_q, vTotal_q;

  logic        lineEdge, frameEdge, timeout, badLine, badFrame;
  logic [11:0] hLen, vLen;

  // Lengths are formed one bit wider so a saturated counter never aliases a valid total.
  assign hLen      = {1'b0, hcount_q} + 12'd1;
  assign vLen      = {1'b0, vcount_q} + 12'd1;
  assign lineEdge  = hblnk_q & ~hblnk_in;
  assign frameEdge = lineEdge & vblnk_line_q & ~vblnk_in;
  assign timeout   = (hcount_q == CountMaxC);
  assign badLine   = timeout | (lineEdge & ~frameEdge & (hLen != HTotalC));
  assign badFrame  = frameEdge & ((vLen != VTotalC) | lineErr_q | badLine);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    errCnt_d  = errCnt_q;
    lineErr_d = frameEdge ? 1'b0 : (badLine ? 1'b1 : lineErr_q);
    unique case (state_q)
      SEARCH: begin
        if (frameEdge && !timeout) begin
          state_d = MEASURE;
          good_d  = 4'd0;
        end
      end
      MEASURE: begin
        if (timeout) begin
          state_d = SEARCH;
        end else if (frameEdge) begin
          if (badFrame) begin
            good_d = 4'd0;
          end else begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LockFramesC) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (badLine || badFrame) begin
          state_d = SEARCH;
          if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      good_q    <= 4'd0;
      errCnt_q  <= 8'd0;
      lineErr_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      errCnt_q  <= errCnt_d;
      lineErr_q <= lineErr_d;
      locked_q  <= (state_d == LOCKED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hblnk_q      <= 1'b0;
      vblnk_line_q <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      hblnkOut_q   <= 1'b0;
      vblnkOut_q   <= 1'b0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
      hcount_q     <= 11'd0;
      vcount_q     <= 11'd0;
      hTotal_q     <= 11'd0;
      vTotal_q     <= 11'd0;
    end else begin
      hblnk_q      <= hblnk_in;
      hsync_q      <= hsync_in;
      vsync_q      <= vsync_in;
      hblnkOut_q   <= hblnk_in;
      vblnkOut_q   <= vblnk_in;
      lineStart_q  <= lineEdge;
      frameStart_q <= frameEdge;
      if (lineEdge) begin
        hcount_q     <= 11'd0;
        hTotal_q     <= hLen[10:0];
        vblnk_line_q <= vblnk_in;
      end else if (!timeout) begin
        hcount_q <= hcount_q + 11'd1;
      end
      if (frameEdge) begin
        vcount_q <= 11'd0;
        vTotal_q <= vLen[10:0];
      end else if (lineEdge && vcount_q != CountMaxC) begin
        vcount_q <= vcount_q + 11'd1;
      end
    end
  end

  assign hsync_out    = hsync_q;
  assign vsync_out    = vsync_q;
  assign hblnk_out    = hblnkOut_q;
  assign vblnk_out    = vblnkOut_q;
  assign hcount_out   = hcount_q;
  assign vcount_out   = vcount_q;
  assign line_start   = lineStart_q;
  assign frame_start  = frameStart_q;
  assign h_total_meas = hTotal_q;
  assign v_total_meas = vTotal_q;
  assign locked       = locked_q;
  assign err_cnt      = errCnt_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Self-checking bench for vga_timing_decoder: small-geometry sync streams with random
// perturbations, compared every cycle against an event-level reference model.
module tb_vga_timing_decoder;

  localparam int HT   = 8;
  localparam int VT   = 4;
  localparam int LF   = 2;
  localparam int CMAX = 2047;

  localparam int SEARCHING = 0;
  localparam int MEASURING = 1;
  localparam int LOCKEDM   = 2;

  logic        clk;
  logic        rst_n;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [10:0] hcount_out, vcount_out, h_total_meas, v_total_meas;
  logic        line_start, frame_start, locked;
  logic [7:0]  err_cnt;

  int total, bad, fsSeen;

  // Reference model: time stamps of line edges, line counts since frame edge, lock mode.
  int mCycle, mLastLe, mLines, mMode, mGood, mErr, expHMeas, expVMeas;
  bit mPrevHb, mLineVb, mDirty, mLe, mFe;

  vga_timing_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .rst_n(rst_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .line_start(line_start), .frame_start(frame_start),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
    .locked(locked), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampCount(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mCycle = 0; mLastLe = 0; mLines = 0; mMode = SEARCHING; mGood = 0; mErr = 0;
    mPrevHb = 0; mLineVb = 0; mDirty = 0; mLe = 0; mFe = 0;
    expHMeas = 0; expVMeas = 0;
  endtask

  task automatic modelStep(input bit hb, input bit vb);
    int prevH, prevV, len;
    bit tmo, lineBad, frameBad;
    mCycle++;
    prevH    = clampCount(mCycle - 1 - mLastLe);
    prevV    = clampCount(mLines);
    len      = mCycle - mLastLe;
    mLe      = mPrevHb && !hb;
    mFe      = mLe && mLineVb && !vb;
    tmo      = (prevH == CMAX);
    lineBad  = tmo || (mLe && !mFe && len != HT);
    frameBad = mFe && ((prevV + 1) != VT || mDirty || lineBad);
    case (mMode)
      SEARCHING: if (mFe && !tmo) begin mMode = MEASURING; mGood = 0; end
      MEASURING: begin
        if (tmo) mMode = SEARCHING;
        else if (mFe) begin
          if (frameBad) mGood = 0;
          else begin
            mGood++;
            if (mGood == LF) mMode = LOCKEDM;
          end
        end
      end
      default: if (lineBad || frameBad) begin
        mMode = SEARCHING;
        if (mErr < 255) mErr++;
      end
    endcase
    if (mFe) mDirty = 0;
    else if (lineBad) mDirty = 1;
    if (mLe) begin
      expHMeas = (len > CMAX) ? 0 : len;
      mLastLe  = mCycle;
      mLineVb  = vb;
    end
    if (mFe) begin
      expVMeas = (prevV + 1) % 2048;
      mLines   = 0;
    end else if (mLe) begin
      mLines++;
    end
    mPrevHb = hb;
  endtask

  task automatic applyStimulus(input bit hb, input bit vb);
    bit hs, vs;
    hs = 1'($urandom);
    vs = 1'($urandom);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    @(posedge clk);
    #1;
    modelStep(hb, vb);
    if (frame_start === 1'b1) fsSeen++;
    checkOutput("hcount",     32'(hcount_out),   32'(clampCount(mCycle - mLastLe)));
    checkOutput("vcount",     32'(vcount_out),   32'(clampCount(mLines)));
    checkOutput("lineStart",  32'(line_start),   32'(mLe));
    checkOutput("frameStart", 32'(frame_start),  32'(mFe));
    checkOutput("hTotalMeas", 32'(h_total_meas), 32'(expHMeas));
    checkOutput("vTotalMeas", 32'(v_total_meas), 32'(expVMeas));
    checkOutput("locked",     32'(locked),       32'(mMode == LOCKEDM));
    checkOutput("errCnt",     32'(err_cnt),      32'(mErr));
    checkOutput("hsyncOut",   32'(hsync_out),    32'(hs));
    checkOutput("vsyncOut",   32'(vsync_out),    32'(vs));
    checkOutput("hblnkOut",   32'(hblnk_out),    32'(hb));
    checkOutput("vblnkOut",   32'(vblnk_out),    32'(vb));
  endtask

  task automatic sendLine(input int len, input bit vb);
    for (int i = 0; i < len; i++) applyStimulus(i >= len - 2, vb);
  endtask

  task automatic sendFrame(input int nLines, input int oddLine, input int oddLen);
    for (int l = 0; l < nLines; l++) sendLine((l == oddLine) ? oddLen : HT, l == nLines - 1);
  endtask

  task automatic holdBlank(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Hcount"}, 32'(hcount_out),   0);
    checkOutput({tag, "Vcount"}, 32'(vcount_out),   0);
    checkOutput({tag, "HMeas"},  32'(h_total_meas), 0);
    checkOutput({tag, "VMeas"},  32'(v_total_meas), 0);
    checkOutput({tag, "Strobe"}, 32'({line_start, frame_start}), 0);
    checkOutput({tag, "Delay"},  32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 0);
    checkOutput({tag, "Locked"}, 32'(locked),  0);
    checkOutput({tag, "ErrCnt"}, 32'(err_cnt), 0);
  endtask

  initial begin
    #2_000_000;
    bad++;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int nL, odd, oddLen;
    total = 0; bad = 0; fsSeen = 0;
    rst_n = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("rst");
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();

    $display("[TB] ideal stream, acquire lock");
    repeat (5) sendFrame(VT, -1, HT);
    checkOutput("idealLocked", 32'(locked), 1);
    checkOutput("idealHMeas", 32'(h_total_meas), HT);
    checkOutput("idealVMeas", 32'(v_total_meas), VT);
    checkOutput("idealErr", 32'(err_cnt), 0);

    $display("[TB] short line while locked");
    sendFrame(VT, 1, HT - 1);
    checkOutput("shortLocked", 32'(locked), 0);
    checkOutput("shortErr", 32'(err_cnt), 1);
    repeat (4) sendFrame(VT, -1, HT);
    checkOutput("relock1", 32'(locked), 1);

    $display("[TB] short frame while locked");
    sendFrame(VT - 1, -1, HT);
    sendLine(HT, 1'b0);
    checkOutput("shortFrameVMeas", 32'(v_total_meas), VT - 1);
    checkOutput("shortFrameLocked", 32'(locked), 0);
    checkOutput("shortFrameErr", 32'(err_cnt), 2);
    sendLine(HT, 1'b0); sendLine(HT, 1'b0); sendLine(HT, 1'b1);
    repeat (4) sendFrame(VT, -1, HT);
    checkOutput("relock2", 32'(locked), 1);

    $display("[TB] blank timeout while locked and while measuring");
    sendLine(HT, 1'b0);
    holdBlank(3000);
    checkOutput("tmoLockHcount", 32'(hcount_out), CMAX);
    checkOutput("tmoLockLocked", 32'(locked), 0);
    checkOutput("tmoLockErr", 32'(err_cnt), 3);
    repeat (2) sendFrame(VT, -1, HT);
    sendLine(HT, 1'b0);
    holdBlank(3000);
    checkOutput("tmoMeasHcount", 32'(hcount_out), CMAX);
    checkOutput("tmoMeasErr", 32'(err_cnt), 3);

    $display("[TB] randomized frames");
    for (int f = 0; f < 60; f++) begin
      nL     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(VT - 1, VT + 1)) : VT;
      odd    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nL - 1)) : -1;
      oddLen = int'($urandom_range(HT - 1, HT + 1));
      sendFrame(nL, odd, oddLen);
    end

    $display("[TB] reset in the middle of a line");
    sendLine(HT, 1'b0);
    for (int i = 0; i < HT / 2; i++) applyStimulus(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkResetValues("midRst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    fsSeen = 0;
    for (int i = HT / 2; i < HT; i++) applyStimulus(i >= HT - 2, 1'b0);
    sendLine(HT, 1'b0);
    sendLine(HT, 1'b1);
    checkOutput("noEarlyFs", 32'(fsSeen), 0);
    sendLine(HT, 1'b0);
    checkOutput("fsAfterRst", 32'(fsSeen), 1);
    checkOutput("vcountAtFs", 32'(vcount_out), 0);
    sendLine(HT, 1'b0); sendLine(HT, 1'b0); sendLine(HT, 1'b1);

    $display("[TB] repeated lock losses");
    for (int k = 0; k < 260; k++) begin
      repeat (3) sendFrame(VT, -1, HT);
      sendFrame(VT, 1, HT - 1);
    end
    checkOutput("errSaturated", 32'(err_cnt), 255);
    checkOutput("satLocked", 32'(locked), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
